// File: rtl/mult_prod_accum.sv
// Accumulates a frame of unsigned products from an upstream multiplier and
// presents the frame sum, sticky overflow and saturating beat count downstream.
module mult_prod_accum #(
  parameter int unsigned PROD_W = 8,
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  input  logic              in_last,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf,
  output logic [CNT_W-1:0]  out_cnt
);

  localparam int unsigned SUM_W = ACC_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic               out_ovf_q, out_ovf_d;
  logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
  logic               out_valid_q;

  logic               accept;
  logic [SUM_W-1:0]   sum_ext;
  logic               ovf_upd;
  logic [CNT_W-1:0]   cnt_upd;

  // Ready is combinational so a held result and a new beat can swap without a bubble
  assign in_ready = (state_q != S_HOLD) || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  assign sum_ext  = {1'b0, acc_q} + SUM_W'(in_product);
  assign ovf_upd  = ovf_q | sum_ext[ACC_W];
  assign cnt_upd  = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    out_sum_d = out_sum_q;
    out_ovf_d = out_ovf_q;
    out_cnt_d = out_cnt_q;

    if (flush) begin
      // A held result survives flush; it is only released by out_ready
      acc_d = '0;
      ovf_d = 1'b0;
      cnt_d = '0;
      if (state_q == S_HOLD) begin
        state_d = out_ready ? S_IDLE : S_HOLD;
      end else begin
        state_d = S_IDLE;
      end
    end else if (accept) begin
      if (in_last) begin
        out_sum_d = sum_ext[ACC_W-1:0];
        out_ovf_d = ovf_upd;
        out_cnt_d = cnt_upd;
        acc_d     = '0;
        ovf_d     = 1'b0;
        cnt_d     = '0;
        state_d   = S_HOLD;
      end else begin
        acc_d   = sum_ext[ACC_W-1:0];
        ovf_d   = ovf_upd;
        cnt_d   = cnt_upd;
        state_d = S_ACC;
      end
    end else if ((state_q == S_HOLD) && out_ready) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_cnt_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
      out_cnt_q   <= out_cnt_d;
      out_valid_q <= (state_d == S_HOLD);
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;
  assign out_cnt   = out_cnt_q;

endmodule

// File: tb/tb_mult_prod_accum.sv
// Directed bench for mult_prod_accum: frame-level reference model plus literal checks.
module tb_mult_prod_accum;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_product = '0;
  logic        in_last = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_sum;
  logic        out_ovf;
  logic [7:0]  out_cnt;

  int vectors = 0;
  int miscompares = 0;
  bit cmp_en = 1'b0;

  mult_prod_accum #(.PROD_W(8), .ACC_W(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_product(in_product),
    .in_last(in_last), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf), .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint got, input longint exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Frame model: exact integer sum of the frame, reduced only when a result is formed
  bit     m_hold = 1'b0;
  longint m_sum  = 0;
  int     m_n    = 0;
  longint r_sum  = 0;
  int     r_ovf  = 0;
  int     r_cnt  = 0;

  always @(posedge clk) begin
    bit rdy;
    rdy = !m_hold || out_ready;
    if (rst) begin
      m_hold = 0; m_sum = 0; m_n = 0; r_sum = 0; r_ovf = 0; r_cnt = 0;
    end else if (flush) begin
      m_sum = 0; m_n = 0;
      if (m_hold && out_ready) m_hold = 0;
    end else if (in_valid && rdy) begin
      m_sum = m_sum + longint'(in_product);
      m_n   = m_n + 1;
      if (in_last) begin
        r_sum  = m_sum % 65536;
        r_ovf  = (m_sum > 65535) ? 1 : 0;
        r_cnt  = (m_n > 255) ? 255 : m_n;
        m_sum  = 0; m_n = 0; m_hold = 1;
      end else begin
        m_hold = 0;
      end
    end else if (m_hold && out_ready) begin
      m_hold = 0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_out_valid", longint'(out_valid), longint'(m_hold));
      chk("model_in_ready", longint'(in_ready), longint'(!m_hold || out_ready));
      if (m_hold) begin
        chk("model_out_sum", longint'(out_sum), r_sum);
        chk("model_out_ovf", longint'(out_ovf), longint'(r_ovf));
        chk("model_out_cnt", longint'(out_cnt), longint'(r_cnt));
      end
    end
  end

  task automatic drive(input bit v, input logic [7:0] p, input bit l, input bit f, input bit ordy);
    in_valid = v; in_product = p; in_last = l; flush = f; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_res(input string name, input int s, input int o, input int c);
    chk({name, "_valid"}, longint'(out_valid), 1);
    chk({name, "_sum"}, longint'(out_sum), longint'(s));
    chk({name, "_ovf"}, longint'(out_ovf), longint'(o));
    chk({name, "_cnt"}, longint'(out_cnt), longint'(c));
  endtask

  initial begin
    rst = 1'b1;
    drive(1, 8'd55, 1, 0, 1);
    drive(1, 8'd55, 1, 0, 1);
    chk("reset_valid", longint'(out_valid), 0);
    chk("reset_sum", longint'(out_sum), 0);
    chk("reset_ovf", longint'(out_ovf), 0);
    chk("reset_cnt", longint'(out_cnt), 0);
    rst = 1'b0;
    cmp_en = 1'b1;
    drive(0, 0, 0, 0, 0);
    chk("ready_after_reset", longint'(in_ready), 1);

    // 9 + 225 + 15
    drive(1, 8'd9, 0, 0, 1);
    drive(1, 8'd225, 0, 0, 1);
    drive(1, 8'd15, 1, 0, 1);
    chk_res("three_beat", 249, 0, 3);
    drive(0, 0, 0, 0, 1);
    chk("three_beat_released", longint'(out_valid), 0);

    // 258 x 255 wraps past 2^16 and saturates the count
    for (int i = 0; i < 257; i++) drive(1, 8'd255, 0, 0, 1);
    drive(1, 8'd255, 1, 0, 1);
    chk_res("long_frame", 254, 1, 255);
    drive(0, 0, 0, 0, 1);

    // Backpressure then no-bubble handover
    drive(1, 8'd50, 1, 0, 0);
    chk_res("held_load", 50, 0, 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_product = 8'd99; in_last = 1'b0; flush = 1'b0; out_ready = 1'b0;
      #1;
      chk("held_in_ready", longint'(in_ready), 0);
      drive(1, 8'd99, 0, 0, 0);
      chk_res("held_stable", 50, 0, 1);
    end
    drive(1, 8'd7, 1, 0, 1);
    chk_res("handover", 7, 0, 1);

    // Back-to-back single-beat frames
    for (int k = 1; k <= 4; k++) begin
      drive(1, 8'(k * 11), 1, 0, 1);
      chk_res("b2b", k * 11, 0, 1);
    end
    drive(0, 0, 0, 0, 1);

    // Flush mid-frame discards partial sum and the concurrent beat
    drive(1, 8'd10, 0, 0, 1);
    drive(1, 8'd20, 0, 0, 1);
    drive(1, 8'd77, 1, 1, 1);
    chk("flush_no_result", longint'(out_valid), 0);
    drive(1, 8'd5, 1, 0, 1);
    chk_res("after_flush", 5, 0, 1);
    drive(0, 0, 0, 0, 1);

    // Flush during HOLD keeps the result
    drive(1, 8'd100, 1, 0, 0);
    drive(1, 8'd33, 0, 1, 0);
    chk_res("hold_flush", 100, 0, 1);
    drive(0, 0, 0, 0, 1);
    chk("hold_flush_released", longint'(out_valid), 0);
    drive(1, 8'd4, 1, 0, 1);
    chk_res("hold_flush_next", 4, 0, 1);
    drive(0, 0, 0, 0, 1);

    // Reset mid-frame
    drive(1, 8'd3, 0, 0, 1);
    drive(1, 8'd4, 0, 0, 1);
    rst = 1'b1;
    drive(1, 8'd8, 1, 0, 1);
    chk("mid_reset_valid", longint'(out_valid), 0);
    rst = 1'b0;
    drive(1, 8'd6, 1, 0, 1);
    chk_res("after_reset", 6, 0, 1);

    // Reset drops a held result
    drive(1, 8'd90, 1, 0, 0);
    rst = 1'b1;
    drive(0, 0, 0, 1, 0);
    chk("reset_drops_hold", longint'(out_valid), 0);
    chk("reset_drops_sum", longint'(out_sum), 0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
